// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: one req/ack handshake with
// its command fields (we, addr, wdata) and the returned read data.
// The requester uses the master modport and the arbiter the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous Memory between the
// CPU and an external requester (loader/debug). One transaction is in
// flight at a time: IDLE -> ISSUE -> (WAIT x READ_LATENCY) -> DONE.
// Every output is registered; each register is loaded from the value the
// next-state logic computes for the coming cycle.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on simultaneous requests the
// requester not granted last wins (CPU wins the first tie). Without it the
// CPU always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_arbiter_if.slave     cpu,
  mem_port_arbiter_if.slave     ext,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  grant_ext
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [2:0]            wait_cnt, wait_cnt_n;
  logic                  lat_we, lat_we_n;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_n;
  logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_n;
  logic                  pick_ext;
  logic                  grant_ext_n;
  logic                  cpu_ack_n, ext_ack_n;
  logic [DATA_WIDTH-1:0] cpu_rdata_n, ext_rdata_n;
  logic [ADDR_WIDTH-1:0] mem_address_n;
  logic [DATA_WIDTH-1:0] mem_data_n;
  logic                  mem_wren_n;
  logic                  busy_n;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_ext, last_ext_n;

  // Tie-break: on a tie the requester that was not granted last wins.
  always_comb begin
    pick_ext = ext.req && (!cpu.req || !last_ext);
  end
`else
  // Tie-break: fixed priority, ext only wins when the CPU is not asking.
  always_comb begin
    pick_ext = ext.req && !cpu.req;
  end
`endif

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    lat_we_n    = lat_we;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    grant_ext_n = grant_ext;
    cpu_rdata_n = cpu.rdata;
    ext_rdata_n = ext.rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_ext_n  = last_ext;
`endif

    case (state)
      IDLE: begin
        if (cpu.req || ext.req) begin
          grant_ext_n = pick_ext;
          lat_we_n    = pick_ext ? ext.we    : cpu.we;
          lat_addr_n  = pick_ext ? ext.addr  : cpu.addr;
          lat_wdata_n = pick_ext ? ext.wdata : cpu.wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_ext_n  = pick_ext;
`endif
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          state_n = DONE;
        end else begin
          wait_cnt_n = 3'(READ_LATENCY);
          state_n    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_n = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          if (grant_ext) begin
            ext_rdata_n = mem_q;
          end else begin
            cpu_rdata_n = mem_q;
          end
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    mem_address_n = ((state_n == ISSUE) || (state_n == WAIT)) ? lat_addr_n : '0;
    mem_wren_n    = (state_n == ISSUE) && lat_we_n;
    mem_data_n    = mem_wren_n ? lat_wdata_n : '0;
    cpu_ack_n     = (state_n == DONE) && !grant_ext_n;
    ext_ack_n     = (state_n == DONE) && grant_ext_n;
    busy_n        = (state_n != IDLE);
  end

  // State, latched command and all registered outputs; synchronous reset
  // abandons any transaction in flight without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      grant_ext   <= 1'b0;
      cpu.ack     <= 1'b0;
      ext.ack     <= 1'b0;
      cpu.rdata   <= '0;
      ext.rdata   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      lat_we      <= lat_we_n;
      lat_addr    <= lat_addr_n;
      lat_wdata   <= lat_wdata_n;
      grant_ext   <= grant_ext_n;
      cpu.ack     <= cpu_ack_n;
      ext.ack     <= ext_ack_n;
      cpu.rdata   <= cpu_rdata_n;
      ext.rdata   <= ext_rdata_n;
      mem_address <= mem_address_n;
      mem_data    <= mem_data_n;
      mem_wren    <= mem_wren_n;
      busy        <= busy_n;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-grant flag starts at ext so the CPU takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_ext <= 1'b1;
    end else begin
      last_ext <= last_ext_n;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Holds a Memory model with a READ_LATENCY
// deep read pipeline, a transaction-level reference model that pushes the
// expected outcome of every accepted request into a scoreboard, and a
// monitor that compares all DUT outputs every cycle against it.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to exercise round-robin ties.
module tb_mem_port_arbiter;

  localparam int TB_RL = 3;

  logic        clock;
  logic        reset;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;
  logic        busy;
  logic        grant_ext;

  mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) cpu_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) ext_if ();

  mem_port_arbiter #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16),
    .READ_LATENCY(TB_RL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu        (cpu_if),
    .ext        (ext_if),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .busy       (busy),
    .grant_ext  (grant_ext)
  );

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    int          acc;
    int          done;
  } txn_t;

  txn_t        sb[$];
  int          asserts  = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          free_at  = 0;
  bit          last_ext_m = 1'b1;
  logic [15:0] ref_mem [65536];
  logic [15:0] mem_array [65536];
  logic [15:0] q_pipe [TB_RL];
  logic [15:0] exp_cpu_rdata = 16'h0;
  logic [15:0] exp_ext_rdata = 16'h0;
  bit          exp_grant = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Memory model: write on wren, read data appears TB_RL edges after the
  // address edge.
  always @(posedge clock) begin
    if (mem_wren) mem_array[mem_address] <= mem_data;
    q_pipe[0] <= mem_array[mem_address];
    for (int i = 1; i < TB_RL; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[TB_RL-1];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time; an IDLE cycle with a request
  // accepts it, writes finish 2 cycles later, reads 2+TB_RL cycles later.
  always @(negedge clock) begin
    txn_t t;
    bit   win;
    if (reset) begin
      sb.delete();
      free_at    = cyc + 1;
      last_ext_m = 1'b1;
    end else if (cyc >= free_at && (cpu_if.req || ext_if.req)) begin
      if (cpu_if.req && ext_if.req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = !last_ext_m;
`else
        win = 1'b0;
`endif
      end else begin
        win = ext_if.req;
      end
      last_ext_m = win;
      t.is_ext = win;
      t.we     = win ? ext_if.we : cpu_if.we;
      t.addr   = win ? ext_if.addr : cpu_if.addr;
      if (t.we) begin
        t.data = win ? ext_if.wdata : cpu_if.wdata;
        ref_mem[t.addr] = t.data;
      end else begin
        t.data = ref_mem[t.addr];
      end
      t.acc   = cyc;
      t.done  = cyc + (t.we ? 2 : 2 + TB_RL);
      free_at = t.done + 1;
      sb.push_back(t);
    end
  end

  // Monitor: derives every expected output for this cycle from the head of
  // the scoreboard and compares, popping once the ack cycle is reached.
  always @(negedge clock) begin
    txn_t        t;
    bit          act;
    logic [15:0] e_addr, e_data;
    bit          e_wren, e_busy, e_cack, e_eack;
    if (reset) begin
      exp_cpu_rdata = 16'h0;
      exp_ext_rdata = 16'h0;
      exp_grant     = 1'b0;
    end else begin
      e_addr = 16'h0; e_data = 16'h0;
      e_wren = 1'b0; e_busy = 1'b0; e_cack = 1'b0; e_eack = 1'b0;
      act = (sb.size() > 0) && (cyc > sb[0].acc);
      if (act) begin
        t = sb[0];
        e_busy    = 1'b1;
        exp_grant = t.is_ext;
        if (cyc < t.done) begin
          e_addr = t.addr;
          if (t.we) begin
            e_wren = 1'b1;
            e_data = t.data;
          end
        end
        if (cyc == t.done) begin
          if (t.is_ext) e_eack = 1'b1; else e_cack = 1'b1;
          if (!t.we) begin
            if (t.is_ext) exp_ext_rdata = t.data; else exp_cpu_rdata = t.data;
          end
        end
      end
      checkOutput("cpu_ack",     16'(cpu_if.ack), 16'(e_cack));
      checkOutput("ext_ack",     16'(ext_if.ack), 16'(e_eack));
      checkOutput("mem_wren",    16'(mem_wren),   16'(e_wren));
      checkOutput("mem_address", mem_address,     e_addr);
      checkOutput("mem_data",    mem_data,        e_data);
      checkOutput("busy",        16'(busy),       16'(e_busy));
      checkOutput("grant_ext",   16'(grant_ext),  16'(exp_grant));
      checkOutput("cpu_rdata",   cpu_if.rdata,    exp_cpu_rdata);
      checkOutput("ext_rdata",   ext_if.rdata,    exp_ext_rdata);
      if (act && cyc >= t.done) void'(sb.pop_front());
    end
  end

  // Raise one request (entered just after a rising edge), wait a bounded
  // time for its ack, then drop req on the edge ending the ack cycle unless
  // the caller keeps it for a back-to-back transaction.
  task automatic applyStimulus(input bit is_ext, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit hold);
    int n;
    bit got;
    if (is_ext) begin
      ext_if.req = 1'b1; ext_if.we = we; ext_if.addr = addr; ext_if.wdata = wdata;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clock);
      n++;
      got = is_ext ? (ext_if.ack === 1'b1) : (cpu_if.ack === 1'b1);
    end
    if (!got) begin
      asserts++;
      failures++;
      $display("[TB] FAIL ack_timeout requester_ext=%0d: got no ack, expected ack within 200 cycles", is_ext);
    end
    @(posedge clock); #1;
    if (!hold) begin
      if (is_ext) ext_if.req = 1'b0; else cpu_if.req = 1'b0;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    return {8'h00, 4'($urandom_range(0, 15)), 4'h0};
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem_array[a] <= init_val(a);
      ref_mem[a]    = init_val(a);
    end
    reset = 1'b1;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 16'h0; cpu_if.wdata = 16'h0;
    ext_if.req = 1'b0; ext_if.we = 1'b0; ext_if.addr = 16'h0; ext_if.wdata = 16'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    $display("[TB] reset released, idling");
    repeat (5) @(posedge clock);
    #1;

    $display("[TB] CPU write then read-back");
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    repeat (10) @(posedge clock);
    #1;

    $display("[TB] simultaneous CPU and ext requests");
    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    fork
      applyStimulus(1'b0, 1'b1, 16'h0040, 16'h5555, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    join
    repeat (2) @(posedge clock);
    #1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    $display("[TB] both requests held, round-robin alternation");
    fork
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, rand_addr(), 16'h0, i < 3);
      for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, rand_addr(), 16'h0, j < 3);
    join
    repeat (2) @(posedge clock);
    #1;
`endif

    $display("[TB] reset on the edge that would start an ext write");
    ext_if.req = 1'b1; ext_if.we = 1'b1; ext_if.addr = 16'h0030; ext_if.wdata = 16'hDEAD;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ext_if.req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

    $display("[TB] reset in the middle of an ext read");
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 16'h0040;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; ext_if.req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;

    $display("[TB] back-to-back CPU reads with req held");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 16'h0010 + 16'(k * 16), 16'h0, k < 3);
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] randomized traffic from both requesters");
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #0;
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 1'b0);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #0;
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 1'b0);
      end
    join
    repeat (10) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
